// File: rtl/mshr_pkg.sv
// Shared types for the MSHR entry allocator.
package mshr_pkg;

  localparam int ENTRY_NUM_DFLT = 32;
  localparam int ENTRY_ID_W_DFLT = $clog2(ENTRY_NUM_DFLT);

  typedef logic [ENTRY_ID_W_DFLT-1:0] entry_id_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } mshr_state_e;

endpackage

// File: rtl/cmn_rr_arb.sv
// Round-robin arbiter: search starts at ptr, first requester found wins (one-hot).
module cmn_rr_arb #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic found;
  int   idx;

  // walk requesters in rotated order beginning at ptr
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mshr_entry_arb.sv
// MSHR entry allocator: free bitmap, lowest-free pick, round-robin grant, flush drain.
//
//   state | meaning
//   RUN   | normal allocation and release
//   DRAIN | allocation stopped, waiting for every entry to be released
//   DONE  | drain complete, flush_done asserted for this single cycle
module mshr_entry_arb
  import mshr_pkg::*;
#(
  parameter int ENTRY_NUM      = 32,
  parameter int ENTRY_ID_WIDTH = $clog2(ENTRY_NUM),
  parameter int REQ_NUM        = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REQ_NUM-1:0]        req_vld,
  output logic [REQ_NUM-1:0]        req_rdy,
  output logic [ENTRY_ID_WIDTH-1:0] gnt_idx,
  input  logic                      rel_vld,
  input  logic [ENTRY_ID_WIDTH-1:0] rel_idx,
  input  logic                      flush_req,
  output logic                      flush_done,
  output logic [ENTRY_ID_WIDTH:0]   free_cnt,
  output logic                      full,
  output logic                      err_dbl_rel
);

  localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam logic [ENTRY_ID_WIDTH:0] CNT_ALL = (ENTRY_ID_WIDTH+1)'(ENTRY_NUM);

  logic [ENTRY_NUM-1:0]    bitmap_q, bitmap_d;
  logic [ENTRY_ID_WIDTH:0] free_cnt_q, free_cnt_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  mshr_state_e             state_q, state_d;
  logic                    full_q, err_q, done_q;
  logic                    grant_en, alloc, rel_ok, rel_dbl;
  logic [REQ_NUM-1:0]      eligible, gnt_oh;

  // lowest free entry, from registered state only
  always_comb begin
    gnt_idx = '0;
    for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
      if (bitmap_q[i]) gnt_idx = ENTRY_ID_WIDTH'(i);
    end
  end

  // flush_req blocks grants in the very cycle it is seen; reset blocks them too
  assign grant_en = (state_q == ST_RUN) && !full_q && !flush_req && !rst;
  assign eligible = req_vld & {REQ_NUM{grant_en}};

  cmn_rr_arb #(
    .N     (REQ_NUM),
    .PTR_W (PTR_W)
  ) u_rr_arb (
    .req (eligible),
    .ptr (rr_ptr_q),
    .gnt (gnt_oh)
  );

  assign req_rdy = gnt_oh;
  assign alloc   = |gnt_oh;
  // releasing a free entry (including the one being granted now) is an error, not a set
  assign rel_ok  = rel_vld & ~bitmap_q[rel_idx];
  assign rel_dbl = rel_vld &  bitmap_q[rel_idx];

  // bitmap, counter and pointer next values
  always_comb begin
    bitmap_d = bitmap_q;
    if (alloc)  bitmap_d[gnt_idx] = 1'b0;
    if (rel_ok) bitmap_d[rel_idx] = 1'b1;

    free_cnt_d = free_cnt_q;
    case ({rel_ok, alloc})
      2'b10:   free_cnt_d = free_cnt_q + 1'b1;
      2'b01:   free_cnt_d = free_cnt_q - 1'b1;
      default: free_cnt_d = free_cnt_q;
    endcase

    rr_ptr_d = rr_ptr_q;
    for (int i = 0; i < REQ_NUM; i++) begin
      if (gnt_oh[i]) rr_ptr_d = (i == REQ_NUM - 1) ? '0 : PTR_W'(i + 1);
    end
  end

  // flush sequencing next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (flush_req) state_d = ST_DRAIN;
      ST_DRAIN: if (free_cnt_q == CNT_ALL) state_d = ST_DONE;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // state registers; output flags registered so they are glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      bitmap_q   <= '1;
      free_cnt_q <= CNT_ALL;
      rr_ptr_q   <= '0;
      state_q    <= ST_RUN;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      bitmap_q   <= bitmap_d;
      free_cnt_q <= free_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      state_q    <= state_d;
      full_q     <= (free_cnt_d == '0);
      err_q      <= rel_dbl;
      done_q     <= (state_d == ST_DONE);
    end
  end

  assign free_cnt    = free_cnt_q;
  assign full        = full_q;
  assign err_dbl_rel = err_q;
  assign flush_done  = done_q;

endmodule

// File: tb/tb_mshr_entry_arb.sv
// Randomized + directed bench for mshr_entry_arb against a behavioural pool model.
module tb_mshr_entry_arb;
  import mshr_pkg::*;

  localparam int NE = 32;
  localparam int NR = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_vld;
  logic [NR-1:0]   req_rdy;
  entry_id_t       gnt_idx;
  logic            rel_vld;
  entry_id_t       rel_idx;
  logic            flush_req;
  logic            flush_done;
  logic [5:0]      free_cnt;
  logic            full;
  logic            err_dbl_rel;

  int errs   = 0;
  int checks = 0;

  // model: which entries are free, rotation pointer, mode 0=run 1=drain 2=done
  bit m_free [NE];
  int m_rr;
  int m_mode;
  bit m_err;
  bit m_done;

  always #5 clk = ~clk;

  mshr_entry_arb dut (
    .clk         (clk),
    .rst         (rst),
    .req_vld     (req_vld),
    .req_rdy     (req_rdy),
    .gnt_idx     (gnt_idx),
    .rel_vld     (rel_vld),
    .rel_idx     (rel_idx),
    .flush_req   (flush_req),
    .flush_done  (flush_done),
    .free_cnt    (free_cnt),
    .full        (full),
    .err_dbl_rel (err_dbl_rel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < NE; i++) c += m_free[i];
    return c;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NE; i++) m_free[i] = 1'b1;
    m_rr = 0; m_mode = 0; m_err = 0; m_done = 0;
  endtask

  // one cycle: drive, compare against model, advance model
  task automatic step(input bit r, input logic [NR-1:0] v, input bit rv, input int ri, input bit fl);
    int cnt, low, win;
    logic [NR-1:0] exp_rdy;
    bit dbl, ok;
    @(negedge clk);
    rst = r; req_vld = v; rel_vld = rv; rel_idx = entry_id_t'(ri); flush_req = fl;
    #1;
    cnt = m_cnt();
    low = 0;
    for (int i = NE - 1; i >= 0; i--) if (m_free[i]) low = i;
    exp_rdy = '0;
    win = -1;
    if (!r && m_mode == 0 && cnt > 0 && !fl) begin
      for (int k = 0; k < NR; k++) begin
        int i;
        i = (m_rr + k) % NR;
        if (win < 0 && v[i]) win = i;
      end
      if (win >= 0) exp_rdy[win] = 1'b1;
    end
    chk("req_rdy", 32'(req_rdy), 32'(exp_rdy));
    chk("gnt_idx", 32'(gnt_idx), low);
    chk("free_cnt", 32'(free_cnt), cnt);
    chk("full", 32'(full), (cnt == 0) ? 1 : 0);
    chk("err_dbl_rel", 32'(err_dbl_rel), 32'(m_err));
    chk("flush_done", 32'(flush_done), 32'(m_done));
    if (r) begin
      m_reset();
    end else begin
      dbl = rv && m_free[ri];
      ok  = rv && !m_free[ri];
      if (win >= 0) begin
        m_free[low] = 1'b0;
        m_rr = (win + 1) % NR;
      end
      if (ok) m_free[ri] = 1'b1;
      case (m_mode)
        0: if (fl) m_mode = 1;
        1: if (cnt == NE) m_mode = 2;
        default: m_mode = 0;
      endcase
      m_err  = dbl;
      m_done = (m_mode == 2);
    end
  endtask

  task automatic do_reset();
    step(1'b1, '1, 1'b0, 0, 1'b0);
    step(1'b1, '1, 1'b0, 0, 1'b0);
  endtask

  initial begin
    int busy[$];
    int ri;
    bit rv;
    logic [NR-1:0] v;

    rst = 1'b1; req_vld = '0; rel_vld = 1'b0; rel_idx = '0; flush_req = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);

    // single requester: idx 0,1,2
    repeat (3) step(1'b0, 4'b0001, 1'b0, 0, 1'b0);

    // all requesters: rotation over 8 cycles
    do_reset();
    repeat (8) step(1'b0, 4'b1111, 1'b0, 0, 1'b0);

    // fill the pool, stall on full, release 5 and regrant it
    do_reset();
    repeat (NE) step(1'b0, 4'b0001, 1'b0, 0, 1'b0);
    repeat (2) step(1'b0, 4'b0001, 1'b0, 0, 1'b0);
    step(1'b0, 4'b0001, 1'b1, 5, 1'b0);
    step(1'b0, 4'b0001, 1'b0, 0, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 0, 1'b0);

    // allocate 3 while releasing 1, then 1 is lowest free
    do_reset();
    repeat (3) step(1'b0, 4'b0010, 1'b0, 0, 1'b0);
    step(1'b0, 4'b0010, 1'b1, 1, 1'b0);
    step(1'b0, 4'b0000, 1'b0, 0, 1'b0);

    // double release of free idx 7
    step(1'b0, 4'b0000, 1'b1, 7, 1'b0);
    repeat (2) step(1'b0, 4'b0000, 1'b0, 0, 1'b0);

    // drain with 4 busy entries released over 6 cycles
    do_reset();
    repeat (4) step(1'b0, 4'b1111, 1'b0, 0, 1'b0);
    step(1'b0, 4'b1111, 1'b0, 0, 1'b1);
    step(1'b0, 4'b1111, 1'b1, 0, 1'b0);
    step(1'b0, 4'b1111, 1'b0, 0, 1'b1);
    step(1'b0, 4'b1111, 1'b1, 1, 1'b0);
    step(1'b0, 4'b1111, 1'b1, 2, 1'b0);
    step(1'b0, 4'b1111, 1'b0, 0, 1'b0);
    step(1'b0, 4'b1111, 1'b1, 3, 1'b0);
    repeat (4) step(1'b0, 4'b1111, 1'b0, 0, 1'b0);

    // flush with pool already empty of allocations
    do_reset();
    step(1'b0, 4'b0000, 1'b0, 0, 1'b1);
    repeat (4) step(1'b0, 4'b0001, 1'b0, 0, 1'b0);

    // reset in the middle of a drain
    step(1'b0, 4'b0000, 1'b0, 0, 1'b1);
    repeat (2) step(1'b0, 4'b0000, 1'b0, 0, 1'b0);
    do_reset();
    repeat (3) step(1'b0, 4'b0000, 1'b0, 0, 1'b0);

    // randomized traffic in alternating fill/drain-heavy phases
    for (int n = 0; n < 3000; n++) begin
      bit heavy_fill;
      heavy_fill = ((n / 200) % 2) == 0;
      v = NR'($urandom);
      if (($urandom % 10) >= (heavy_fill ? 8 : 3)) v = '0;
      rv = ($urandom % 10) < (heavy_fill ? 2 : 7);
      busy.delete();
      for (int i = 0; i < NE; i++) if (!m_free[i]) busy.push_back(i);
      if (busy.size() > 0 && ($urandom % 5) != 0)
        ri = busy[$urandom_range(busy.size() - 1, 0)];
      else
        ri = $urandom_range(NE - 1, 0);
      step(($urandom % 700) == 0, v, rv, ri, ($urandom % 80) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
